// File: rtl/data_axi_responder_pkg.sv
// Shared constants for the CPU data-side AXI responder.
// Holds the fixed AXI attribute values the parent ties onto the bus, the
// transaction ID used for data accesses and the AXI size encodings used by
// the pipeline for byte / half / word accesses.
package data_axi_responder_pkg;

    // Single-beat INCR bursts with no locking, caching or protection attributes.
    localparam logic [7:0] AXI_LEN        = 8'd0;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic       AXI_LOCK       = 1'b0;
    localparam logic [3:0] AXI_CACHE      = 4'd0;
    localparam logic [2:0] AXI_PROT       = 3'd0;
    localparam logic [3:0] DATA_AXI_ID    = 4'd1;

    // AXI size field: log2 of the number of bytes in the beat.
    typedef logic [2:0] axi_size_t;

    localparam axi_size_t SIZE_B = 3'd0;
    localparam axi_size_t SIZE_H = 3'd1;
    localparam axi_size_t SIZE_W = 3'd2;

endpackage

// File: rtl/data_axi_responder.sv
// Memory-side responder for the EX/MEM data request interface.
// Converts each load or store request from the pipeline into one single-beat
// AXI transaction and returns load data. At most one access (read or write)
// is outstanding, so memory ordering is trivially preserved.
//
// Ports
//   clk, reset              clock, synchronous active-high reset
//   read_data_*             load request from EX, accept pulse, data return to MEM
//   write_req, write_data_* store request from EX
//   write_addr_ok           high from the cycle after acceptance through write_ok
//   write_ok                one-cycle pulse when the B response has arrived
//   ar*/r*                  AXI read address and read data channels
//   aw*/w*/b*               AXI write address, write data and write response channels
import data_axi_responder_pkg::*;

module data_axi_responder #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    // load request / response
    input  logic                read_data_req,
    input  logic [2:0]          read_data_size,
    input  logic [ADDR_W-1:0]   read_data_addr,
    output logic                read_data_addr_ok,
    output logic                read_data_ok,
    output logic [DATA_W-1:0]   read_data_rdata,
    // store request / response
    input  logic                write_req,
    input  logic [2:0]          write_data_size,
    input  logic [DATA_W/8-1:0] write_data_wstrb,
    input  logic [ADDR_W-1:0]   write_data_addr,
    input  logic [DATA_W-1:0]   write_data_data,
    output logic                write_addr_ok,
    output logic                write_ok,
    // AXI read address channel
    output logic [ADDR_W-1:0]   araddr,
    output logic [2:0]          arsize,
    output logic                arvalid,
    input  logic                arready,
    // AXI read data channel
    input  logic [DATA_W-1:0]   rdata,
    input  logic                rvalid,
    output logic                rready,
    // AXI write address channel
    output logic [ADDR_W-1:0]   awaddr,
    output logic [2:0]          awsize,
    output logic                awvalid,
    input  logic                awready,
    // AXI write data channel
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    output logic                wvalid,
    input  logic                wready,
    // AXI write response channel
    input  logic                bvalid,
    output logic                bready
);

    typedef enum logic [1:0] {
        R_IDLE,
        R_AR,
        R_DATA
    } r_state_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_SEND,
        W_RESP,
        W_DONE
    } w_state_t;

    r_state_t  r_state, r_next;
    w_state_t  w_state, w_next;

    logic      rd_accept;
    logic      wr_accept;
    logic      aw_pend;
    logic      w_pend;
    logic      aw_fire;
    logic      w_fire;
    axi_size_t ar_size_q;
    axi_size_t aw_size_q;

    // ------------------------------------------------------------------
    // Read FSM: next state and outputs.
    // A load is only accepted when both FSMs are idle and no store is being
    // requested, which gives stores priority and keeps one access in flight.
    // Acceptance is masked during reset so nothing is claimed to be taken
    // in a cycle whose state update the reset discards.
    // ------------------------------------------------------------------
    always_comb begin
        r_next    = r_state;
        rd_accept = (r_state == R_IDLE) && (w_state == W_IDLE) &&
                    read_data_req && !write_req && !reset;
        arvalid   = 1'b0;
        rready    = 1'b0;
        case (r_state)
            R_IDLE: begin
                if (rd_accept) r_next = R_AR;
            end
            R_AR: begin
                arvalid = 1'b1;
                if (arready) r_next = R_DATA;
            end
            R_DATA: begin
                rready = 1'b1;
                if (rvalid) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    assign read_data_addr_ok = rd_accept;
    assign arsize            = ar_size_q;

    // ------------------------------------------------------------------
    // Read FSM: state and payload registers.
    // The AR payload is captured only at acceptance so it stays stable while
    // arvalid waits for arready. Returned data is registered and flagged with
    // read_data_ok one cycle after the R beat.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= R_IDLE;
            araddr          <= '0;
            ar_size_q       <= '0;
            read_data_rdata <= '0;
            read_data_ok    <= 1'b0;
        end else begin
            r_state      <= r_next;
            read_data_ok <= (r_state == R_DATA) && rvalid;
            if (rd_accept) begin
                araddr    <= read_data_addr;
                ar_size_q <= read_data_size;
            end
            if ((r_state == R_DATA) && rvalid) begin
                read_data_rdata <= rdata;
            end
        end
    end

    // ------------------------------------------------------------------
    // Write FSM: next state and outputs.
    // AW and W are issued together; each has its own pending flag so the two
    // handshakes may finish in any order. The FSM leaves W_SEND once neither
    // channel still has an outstanding beat after this cycle's handshakes.
    // ------------------------------------------------------------------
    always_comb begin
        w_next        = w_state;
        wr_accept     = (w_state == W_IDLE) && (r_state == R_IDLE) &&
                        write_req && !reset;
        awvalid       = 1'b0;
        wvalid        = 1'b0;
        bready        = 1'b0;
        write_ok      = 1'b0;
        write_addr_ok = (w_state != W_IDLE);
        case (w_state)
            W_IDLE: begin
                if (wr_accept) w_next = W_SEND;
            end
            W_SEND: begin
                awvalid = aw_pend;
                wvalid  = w_pend;
                if ((!aw_pend || awready) && (!w_pend || wready)) begin
                    w_next = W_RESP;
                end
            end
            W_RESP: begin
                bready = 1'b1;
                if (bvalid) w_next = W_DONE;
            end
            W_DONE: begin
                write_ok = 1'b1;
                w_next   = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
        aw_fire = awvalid && awready;
        w_fire  = wvalid && wready;
    end

    assign awsize = aw_size_q;

    // ------------------------------------------------------------------
    // Write FSM: state, pending flags and payload registers.
    // Payloads load only at acceptance; the pending flags are raised at
    // acceptance and dropped individually by their channel handshakes.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            w_state   <= W_IDLE;
            aw_pend   <= 1'b0;
            w_pend    <= 1'b0;
            awaddr    <= '0;
            aw_size_q <= '0;
            wdata     <= '0;
            wstrb     <= '0;
        end else begin
            w_state <= w_next;
            if (wr_accept) begin
                awaddr    <= write_data_addr;
                aw_size_q <= write_data_size;
                wdata     <= write_data_data;
                wstrb     <= write_data_wstrb;
                aw_pend   <= 1'b1;
                w_pend    <= 1'b1;
            end else begin
                if (aw_fire) aw_pend <= 1'b0;
                if (w_fire)  w_pend  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_data_axi_responder.sv
// Self-checking bench for data_axi_responder.
// A table of directed load/store vectors (with per-channel AXI slave delays
// and hand-computed latencies) is run in a loop, followed by hand-written
// sequences for read/write priority and reset in the middle of a transaction.
import data_axi_responder_pkg::*;

module tb_data_axi_responder;

    logic        clk;
    logic        reset;
    logic        read_data_req;
    logic [2:0]  read_data_size;
    logic [31:0] read_data_addr;
    logic        read_data_addr_ok;
    logic        read_data_ok;
    logic [31:0] read_data_rdata;
    logic        write_req;
    logic [2:0]  write_data_size;
    logic [3:0]  write_data_wstrb;
    logic [31:0] write_data_addr;
    logic [31:0] write_data_data;
    logic        write_addr_ok;
    logic        write_ok;
    logic [31:0] araddr;
    logic [2:0]  arsize;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic [2:0]  awsize;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic        bvalid;
    logic        bready;

    data_axi_responder #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk               (clk),
        .reset             (reset),
        .read_data_req     (read_data_req),
        .read_data_size    (read_data_size),
        .read_data_addr    (read_data_addr),
        .read_data_addr_ok (read_data_addr_ok),
        .read_data_ok      (read_data_ok),
        .read_data_rdata   (read_data_rdata),
        .write_req         (write_req),
        .write_data_size   (write_data_size),
        .write_data_wstrb  (write_data_wstrb),
        .write_data_addr   (write_data_addr),
        .write_data_data   (write_data_data),
        .write_addr_ok     (write_addr_ok),
        .write_ok          (write_ok),
        .araddr            (araddr),
        .arsize            (arsize),
        .arvalid           (arvalid),
        .arready           (arready),
        .rdata             (rdata),
        .rvalid            (rvalid),
        .rready            (rready),
        .awaddr            (awaddr),
        .awsize            (awsize),
        .awvalid           (awvalid),
        .awready           (awready),
        .wdata             (wdata),
        .wstrb             (wstrb),
        .wvalid            (wvalid),
        .wready            (wready),
        .bvalid            (bvalid),
        .bready            (bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Slave response delays (cycles of valid before ready / valid) and R data.
    int          ar_delay = 0, r_delay = 0, aw_delay = 0, w_delay = 0, b_delay = 0;
    int          ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;
    logic [31:0] r_word = '0;

    // Monitor counters, cleared at the start of every vector.
    int          addr_ok_cnt, rok_cnt, wok_cnt, waok_cnt;
    int          arv_cnt, rrdy_cnt, awv_cnt, wv_cnt;
    int          ar_hs, r_hs, aw_hs, w_hs, b_hs;
    int          stab_err = 0;
    logic [31:0] cap_addr, cap_data;
    logic [2:0]  cap_size;
    logic [3:0]  cap_strb;

    logic        prev_arv = 1'b0, prev_awv = 1'b0, prev_wv = 1'b0;
    logic [31:0] prev_araddr, prev_awaddr, prev_wdata;
    logic [2:0]  prev_arsize, prev_awsize;
    logic [3:0]  prev_wstrb;

    typedef struct {
        bit          is_write;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          d_a;
        int          d_d;
        int          d_b;
        int          exp_lat;
        int          exp_avalid;
        int          exp_dvalid;
    } vec_t;

    localparam int NVEC = 7;
    vec_t vecs [NVEC];

    // AXI slave model: ready/valid asserted after the programmed number of
    // cycles that the matching master signal has been high.
    always @(negedge clk) begin
        if (arvalid) begin arready = (ar_cnt >= ar_delay); ar_cnt++; end
        else begin arready = 1'b0; ar_cnt = 0; end
        if (rready) begin rvalid = (r_cnt >= r_delay); rdata = r_word; r_cnt++; end
        else begin rvalid = 1'b0; r_cnt = 0; end
        if (awvalid) begin awready = (aw_cnt >= aw_delay); aw_cnt++; end
        else begin awready = 1'b0; aw_cnt = 0; end
        if (wvalid) begin wready = (w_cnt >= w_delay); w_cnt++; end
        else begin wready = 1'b0; w_cnt = 0; end
        if (bready) begin bvalid = (b_cnt >= b_delay); b_cnt++; end
        else begin bvalid = 1'b0; b_cnt = 0; end
    end

    // Monitor: counts pulses and valid cycles, captures handshake payloads
    // and flags any payload change while a valid is waiting for its ready.
    always @(negedge clk) begin
        #2;
        if (read_data_addr_ok) addr_ok_cnt++;
        if (read_data_ok)      rok_cnt++;
        if (write_ok)          wok_cnt++;
        if (write_addr_ok)     waok_cnt++;
        if (arvalid)           arv_cnt++;
        if (rready)            rrdy_cnt++;
        if (awvalid)           awv_cnt++;
        if (wvalid)            wv_cnt++;
        if (arvalid && arready) begin ar_hs++; cap_addr = araddr; cap_size = arsize; end
        if (awvalid && awready) begin aw_hs++; cap_addr = awaddr; cap_size = awsize; end
        if (wvalid && wready)   begin w_hs++; cap_data = wdata; cap_strb = wstrb; end
        if (rvalid && rready)   r_hs++;
        if (bvalid && bready)   b_hs++;
        if (prev_arv && arvalid && (araddr != prev_araddr || arsize != prev_arsize)) stab_err++;
        if (prev_awv && awvalid && (awaddr != prev_awaddr || awsize != prev_awsize)) stab_err++;
        if (prev_wv && wvalid && (wdata != prev_wdata || wstrb != prev_wstrb)) stab_err++;
        prev_arv    = arvalid && !arready;
        prev_awv    = awvalid && !awready;
        prev_wv     = wvalid && !wready;
        prev_araddr = araddr;
        prev_arsize = arsize;
        prev_awaddr = awaddr;
        prev_awsize = awsize;
        prev_wdata  = wdata;
        prev_wstrb  = wstrb;
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic checkAllZero(input string name);
        checkOutput(name, {read_data_addr_ok, read_data_ok, write_addr_ok, write_ok,
                           arvalid, rready, awvalid, wvalid, bready, arsize, awsize, wstrb}, 64'd0);
        checkOutput({name, "_buses"}, {32'd0, read_data_rdata | araddr | awaddr | wdata}, 64'd0);
    endtask

    task automatic clearCounters();
        addr_ok_cnt = 0; rok_cnt = 0; wok_cnt = 0; waok_cnt = 0;
        arv_cnt = 0; rrdy_cnt = 0; awv_cnt = 0; wv_cnt = 0;
        ar_hs = 0; r_hs = 0; aw_hs = 0; w_hs = 0; b_hs = 0;
        cap_addr = '0; cap_data = '0; cap_size = '0; cap_strb = '0;
    endtask

    // Runs one vector as EX would: hold the request until it is taken, then
    // wait (bounded) for the completion pulse and compare everything seen.
    task automatic applyStimulus(input vec_t v, input int idx);
        int  n;
        int  lat;
        bit  got;
        string tag;
        tag = $sformatf("v%0d", idx);
        @(negedge clk);
        clearCounters();
        if (!v.is_write) begin
            ar_delay = v.d_a; r_delay = v.d_d; r_word = v.data;
            read_data_req  = 1'b1;
            read_data_addr = v.addr;
            read_data_size = v.size;
            got = 0; n = 0;
            while (!got && n < 20) begin
                #2; got = read_data_addr_ok;
                @(negedge clk); n++;
            end
            read_data_req = 1'b0;
            checkOutput({tag, "_accepted"}, got, 1);
            lat = 1; got = 0;
            while (!got && lat < 40) begin
                #2; got = read_data_ok;
                if (!got) begin @(negedge clk); lat++; end
            end
            checkOutput({tag, "_rd_latency"}, lat, v.exp_lat);
            checkOutput({tag, "_rdata"}, read_data_rdata, v.data);
            repeat (3) @(negedge clk);
            checkOutput({tag, "_addr_ok_pulses"}, addr_ok_cnt, 1);
            checkOutput({tag, "_rd_ok_pulses"}, rok_cnt, 1);
            checkOutput({tag, "_arvalid_cycles"}, arv_cnt, v.exp_avalid);
            checkOutput({tag, "_rready_cycles"}, rrdy_cnt, v.exp_dvalid);
            checkOutput({tag, "_ar_handshakes"}, ar_hs, 1);
            checkOutput({tag, "_r_handshakes"}, r_hs, 1);
            checkOutput({tag, "_araddr"}, cap_addr, v.addr);
            checkOutput({tag, "_arsize"}, cap_size, v.size);
        end else begin
            aw_delay = v.d_a; w_delay = v.d_d; b_delay = v.d_b;
            write_req        = 1'b1;
            write_data_addr  = v.addr;
            write_data_size  = v.size;
            write_data_data  = v.data;
            write_data_wstrb = v.strb;
            #2;
            checkOutput({tag, "_waddr_ok_low_at_accept"}, write_addr_ok, 0);
            got = 0; n = 0;
            while (!got && n < 20) begin
                @(negedge clk); #2; got = write_addr_ok; n++;
            end
            write_req = 1'b0;
            checkOutput({tag, "_accepted"}, got, 1);
            lat = 1; got = 0;
            while (!got && lat < 40) begin
                got = write_ok;
                if (!got) begin @(negedge clk); #2; lat++; end
            end
            checkOutput({tag, "_wr_latency"}, lat, v.exp_lat);
            repeat (3) @(negedge clk);
            checkOutput({tag, "_wr_ok_pulses"}, wok_cnt, 1);
            checkOutput({tag, "_waddr_ok_cycles"}, waok_cnt, v.exp_lat);
            checkOutput({tag, "_awvalid_cycles"}, awv_cnt, v.exp_avalid);
            checkOutput({tag, "_wvalid_cycles"}, wv_cnt, v.exp_dvalid);
            checkOutput({tag, "_aw_handshakes"}, aw_hs, 1);
            checkOutput({tag, "_w_handshakes"}, w_hs, 1);
            checkOutput({tag, "_b_handshakes"}, b_hs, 1);
            checkOutput({tag, "_awaddr"}, cap_addr, v.addr);
            checkOutput({tag, "_awsize"}, cap_size, v.size);
            checkOutput({tag, "_wdata"}, cap_data, v.data);
            checkOutput({tag, "_wstrb"}, cap_strb, v.strb);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int  n;
        int  seen;
        bit  got;

        //            wr  size    addr          data          strb   da dd db lat av dv
        vecs[0] = '{1'b0, SIZE_W, 32'h0000_1000, 32'hDEAD_BEEF, 4'h0, 0, 0, 0, 3, 1, 1};
        vecs[1] = '{1'b1, SIZE_B, 32'h0000_1003, 32'hAA00_0000, 4'h8, 2, 0, 4, 9, 3, 1};
        vecs[2] = '{1'b0, SIZE_H, 32'h0000_2002, 32'h5566_7788, 4'h0, 5, 0, 0, 8, 6, 1};
        vecs[3] = '{1'b1, SIZE_W, 32'h0000_3000, 32'h1234_5678, 4'hF, 0, 3, 0, 6, 1, 4};
        vecs[4] = '{1'b1, SIZE_H, 32'h0000_4002, 32'hBEEF_0000, 4'hC, 1, 1, 1, 5, 2, 2};
        vecs[5] = '{1'b0, SIZE_B, 32'h0000_5001, 32'hCAFE_1234, 4'h0, 0, 2, 0, 5, 1, 3};
        vecs[6] = '{1'b0, SIZE_W, 32'h0000_6001, 32'h0BAD_F00D, 4'h0, 0, 0, 0, 3, 1, 1};

        reset = 1'b1;
        read_data_req = 1'b0; read_data_size = '0; read_data_addr = '0;
        write_req = 1'b0; write_data_size = '0; write_data_wstrb = '0;
        write_data_addr = '0; write_data_data = '0;
        arready = 1'b0; rvalid = 1'b0; rdata = '0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
        clearCounters();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #2;
        checkAllZero("reset_state");

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i], i);
        end

        // Both requests together: the store goes first and the load is not
        // accepted until the cycle after write_ok.
        @(negedge clk);
        ar_delay = 0; r_delay = 0; aw_delay = 0; w_delay = 0; b_delay = 0;
        r_word = 32'h1122_3344;
        write_req = 1'b1; write_data_addr = 32'h8000; write_data_size = SIZE_W;
        write_data_data = 32'hA5A5_5A5A; write_data_wstrb = 4'hF;
        read_data_req = 1'b1; read_data_addr = 32'h9000; read_data_size = SIZE_W;
        #2;
        checkOutput("prio_no_rd_accept", read_data_addr_ok, 0);
        got = 0; n = 0; seen = 0;
        while (!got && n < 20) begin
            @(negedge clk); #2;
            if (write_addr_ok) write_req = 1'b0;
            if (read_data_addr_ok) seen++;
            got = write_ok; n++;
        end
        checkOutput("prio_write_done", got, 1);
        checkOutput("prio_write_latency", n, 3);
        checkOutput("prio_rd_held_off", seen, 0);
        @(negedge clk); #2;
        checkOutput("prio_rd_accept_after", read_data_addr_ok, 1);
        @(negedge clk);
        read_data_req = 1'b0;
        n = 1; got = 0;
        while (!got && n < 20) begin
            #2; got = read_data_ok;
            if (!got) begin @(negedge clk); n++; end
        end
        checkOutput("prio_rd_latency", n, 3);
        checkOutput("prio_rdata", read_data_rdata, 32'h1122_3344);

        // Reset while waiting in R_DATA.
        @(negedge clk);
        ar_delay = 0; r_delay = 10;
        read_data_req = 1'b1; read_data_addr = 32'h7000; read_data_size = SIZE_W;
        #2;
        checkOutput("rst_rd_accept", read_data_addr_ok, 1);
        @(negedge clk); read_data_req = 1'b0;
        @(negedge clk); #2;
        checkOutput("rst_rd_in_rdata", rready, 1);
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        #2;
        checkAllZero("rst_in_rdata");
        applyStimulus(vecs[0], 10);

        // Reset while AW and W are both still waiting in W_SEND.
        @(negedge clk);
        aw_delay = 10; w_delay = 10; b_delay = 0;
        write_req = 1'b1; write_data_addr = 32'h7100; write_data_size = SIZE_W;
        write_data_data = 32'h7777_7777; write_data_wstrb = 4'hF;
        @(negedge clk); #2;
        checkOutput("rst_wr_in_send", {awvalid, wvalid}, 2'b11);
        write_req = 1'b0;
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        #2;
        checkAllZero("rst_in_wsend");
        applyStimulus(vecs[1], 11);

        checkOutput("payload_stability", stab_err, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
